calc_req_arbiter: RTL
=====================

Name: calc_req_arbiter

Overview:
Shares the single calculator datapath between two independent requesters (e.g. pin-driven operands and an on-chip test sequencer). Requests are accepted one at a time under round-robin arbitration, launched into the calculator, and the result is returned with the winning requester's ID. Only one transaction is in flight at a time. The block sits between the top-level pin logic and the calculator instance.

Parameters:
A_W, 4, operand A width
B_W, 4, operand B width
RES_W, 8, calculator result width
OP_W, 2, opcode width
CALC_LAT, 2, cycles from calc_start to a valid calc_result (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 handshake accepted this cycle
req0_a  in  A_W  requester 0 operand A
req0_b  in  B_W  requester 0 operand B
req0_op  in  OP_W  requester 0 opcode
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
calc_a  out  A_W  operand A to calculator
calc_b  out  B_W  operand B to calculator
calc_op  out  OP_W  opcode to calculator
calc_start  out  1  one-cycle launch strobe
calc_result  in  RES_W  calculator result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_result  out  RES_W  captured result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; calc_a/b/op=0; calc_start=0; rsp_valid=0; rsp_id=0; rsp_result=0; last_grant=1, so requester 0 wins the first tie; wait counter=0. Reset mid-transaction drops the transaction silently.
- FSM states: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted. If both are high, grant = ~last_grant.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. At most one ready is high in a cycle.
  - On a handshake in cycle H: latch a/b/op into calc_a/b/op, latch the ID, set last_grant=ID, go to LAUNCH.
- LAUNCH (cycle H+1):
  - calc_start=1 for exactly this cycle.
  - Load counter=CALC_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, go to RESP and capture calc_result into rsp_result at the end of cycle H+1+CALC_LAT.
  - calc_a/b/op stay stable from LAUNCH through the end of WAIT.
- RESP:
  - rsp_valid=1 from cycle H+2+CALC_LAT. rsp_result and rsp_id are held stable until accepted.
  - When rsp_valid & rsp_ready: the next state is IDLE and rsp_valid drops.
  - Backpressure is unbounded. No request is accepted while in RESP.
- Throughput: at most one transaction per CALC_LAT+3 cycles, with rsp_ready tied high.
- Request changes:
  - reqN_valid falling before a grant is legal and causes no action.
  - Operand changes after the handshake have no effect.
- busy = (state != IDLE).
- Width rules:
  - No arithmetic on data. rsp_result equals calc_result exactly.
  - The counter is 4 bits.

Decomposition:
- calc_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - the width constants A_W/B_W/RES_W/OP_W;
  - the opcode constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3.
- One sub-module, rr_arb2: a two-way round-robin grant.
  - Inputs: two valids and last_grant.
  - Outputs: grant_valid and grant_id.
  - Purely combinational. The last_grant register stays in calc_req_arbiter.

Test Plan:
1. Single request, CALC_LAT=2.
   - Stimulus: req0 a=3, b=5, op=ADD; model returns 8 at start+2.
   - Required: req0_ready in cycle H; calc_start in H+1; rsp_valid in H+4 with rsp_id=0, rsp_result=8'h08.
2. Simultaneous requests after reset.
   - Stimulus: req0 (2,2,MUL) and req1 (7,1,SUB) both held valid.
   - Required: req0 is served first, giving 8'h04 with id 0. Then req1 is served, giving 8'h06 with id 1. req1_ready never overlaps req0_ready.
3. Fairness.
   - Stimulus: both valids held high for 6 transactions.
   - Required: rsp_id sequence is 0,1,0,1,0,1.
4. Backpressure.
   - Stimulus: rsp_ready held low for 10 cycles during RESP while req1 is valid.
   - Required: rsp_valid, rsp_result and rsp_id are stable. req1_ready stays 0. After the accept, req1 is granted in the following IDLE cycle.
5. Reset mid-flight.
   - Stimulus: assert rst during WAIT.
   - Required: outputs return to reset values on the same edge. No response is emitted. After release, the first tie is won by req0.
6. Operand stability.
   - Stimulus: change req0_a to 4'hF in cycle H+1.
   - Required: calc_a keeps the latched value through WAIT. The result reflects the original operand.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator request arbiter slice.
package calc_pkg;

  localparam int unsigned A_W   = 4;
  localparam int unsigned B_W   = 4;
  localparam int unsigned RES_W = 8;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_AND = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; purely combinational, caller owns last_grant.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    // On a tie the requester that did not win last time goes next.
    grant_id    = (valid0 & valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/calc_req_arbiter.sv
// Shares one calculator between two requesters, one transaction in flight,
// returning each result tagged with the owning requester's ID.
module calc_req_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned CALC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [A_W-1:0]   req0_a,
  input  logic [B_W-1:0]   req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [A_W-1:0]   req1_a,
  input  logic [B_W-1:0]   req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [A_W-1:0]   calc_a,
  output logic [B_W-1:0]   calc_b,
  output logic [OP_W-1:0]  calc_op,
  output logic             calc_start,
  input  logic [RES_W-1:0] calc_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_result,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LatM1 = CNT_W'(CALC_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q;
  logic [A_W-1:0]     calc_a_q;
  logic [B_W-1:0]     calc_b_q;
  logic [OP_W-1:0]    calc_op_q;
  logic               rsp_id_q;
  logic [RES_W-1:0]   rsp_result_q;
  logic               grant_valid, grant_id;
  logic               accept, capture;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = LatM1;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      calc_op_q    <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        calc_a_q     <= grant_id ? req1_a  : req0_a;
        calc_b_q     <= grant_id ? req1_b  : req0_b;
        calc_op_q    <= grant_id ? req1_op : req0_op;
        rsp_id_q     <= grant_id;
        last_grant_q <= grant_id;
      end
      if (capture) rsp_result_q <= calc_result;
    end
  end

  always_comb begin
    req0_ready = (state_q == StIdle) & grant_valid & ~grant_id;
    req1_ready = (state_q == StIdle) & grant_valid & grant_id;
    calc_a     = calc_a_q;
    calc_b     = calc_b_q;
    calc_op    = calc_op_q;
    calc_start = (state_q == StLaunch);
    rsp_valid  = (state_q == StResp);
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    busy       = (state_q != StIdle);
  end

endmodule
